// File: rtl/ps2_letter_fifo.sv
// rtl/ps2_letter_fifo.sv - PS/2 set-2 A..Z decoder feeding a letter FIFO; PS2_PARITY_CHECK_EN enables odd-parity checking
module ps2_letter_fifo #(
   parameter int LETTER_W    = 5,
   parameter int FIFO_DEPTH  = 8,
   parameter int FILTER_LEN  = 4,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              kbdclk,
   input  logic                              kbddat,
   output logic [LETTER_W-1:0]               letter_o,
   output logic                              letter_valid,
   input  logic                              letter_ready,
   output logic [LETTER_W-1:0]               last_letter,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
   output logic                              overflow,
   output logic                              frame_err
);

   localparam int CNT_W = $clog2(FIFO_DEPTH+1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int FLT_W = $clog2(FILTER_LEN) + 1;
   localparam int TMO_W = $clog2(TIMEOUT_CYC+1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;

   logic [1:0]       kclk_sync_q, kdat_sync_q;
   logic             kclk_s, kdat_s;
   logic             kclk_filt_q, kclk_filt_d;
   logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
   logic             fall_edge;

   rx_state_t        state_q, state_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             err_q, err_d;
   logic [7:0]       byte_q, byte_d;
   logic             byte_vld_q, byte_vld_d;
   logic             stop_ok;

   logic             brk_q, brk_d, ext_q, ext_d;
   logic             dec_push_q, dec_push_d;
   logic [4:0]       dec_letter_q, dec_letter_d;
   logic [4:0]       scan_letter;

   logic [LETTER_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                ovf_q, ovf_d;
   logic [LETTER_W-1:0] last_q, last_d;
   logic                full, pop, push_ok;

   assign kclk_s = kclk_sync_q[1];
   assign kdat_s = kdat_sync_q[1];

   // Two-flop synchronisers for the asynchronous PS/2 pins (idle-high)
   always_ff @(posedge clk) begin
      if (rst) begin
         kclk_sync_q <= 2'b11;
         kdat_sync_q <= 2'b11;
      end else begin
         kclk_sync_q <= {kclk_sync_q[0], kbdclk};
         kdat_sync_q <= {kdat_sync_q[0], kbddat};
      end
   end

   // Glitch filter: accept a new kbdclk level only after FILTER_LEN consecutive differing samples
   always_comb begin
      kclk_filt_d = kclk_filt_q;
      flt_cnt_d   = flt_cnt_q;
      fall_edge   = 1'b0;
      if (kclk_s == kclk_filt_q) begin
         flt_cnt_d = '0;
      end else if (flt_cnt_q == FLT_W'(FILTER_LEN-1)) begin
         kclk_filt_d = kclk_s;
         flt_cnt_d   = '0;
         fall_edge   = kclk_filt_q;
      end else begin
         flt_cnt_d = flt_cnt_q + FLT_W'(1);
      end
   end

`ifdef PS2_PARITY_CHECK_EN
   logic par_q;
   // Capture the parity bit so the stop edge can check odd parity over data+parity
   always_ff @(posedge clk) begin
      if (rst)                                par_q <= 1'b0;
      else if (state_q == S_PARITY && fall_edge) par_q <= kdat_s;
   end
   assign stop_ok = kdat_s & (^{shift_q, par_q});
`else
   assign stop_ok = kdat_s;
`endif

   // Receiver next-state: start/data/parity/stop sequencing plus mid-frame timeout
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      err_d      = 1'b0;
      byte_d     = byte_q;
      byte_vld_d = 1'b0;
      tmo_d      = (state_q == S_IDLE || fall_edge) ? '0 : tmo_q + TMO_W'(1);
      case (state_q)
         S_IDLE: if (fall_edge && !kdat_s) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
         end
         S_DATA: if (fall_edge) begin
            shift_d   = {kdat_s, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = S_PARITY;
         end
         S_PARITY: if (fall_edge) state_d = S_STOP;
         S_STOP: if (fall_edge) begin
            state_d = S_IDLE;
            if (stop_ok) begin
               byte_d     = shift_q;
               byte_vld_d = 1'b1;
            end else begin
               err_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (state_q != S_IDLE && !fall_edge && tmo_q == TMO_W'(TIMEOUT_CYC-1)) begin
         state_d = S_IDLE;
         err_d   = 1'b1;
         tmo_d   = '0;
      end
   end

   // Receiver, filter and decoder state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         kclk_filt_q  <= 1'b1;
         flt_cnt_q    <= '0;
         state_q      <= S_IDLE;
         bit_cnt_q    <= 3'd0;
         shift_q      <= 8'd0;
         tmo_q        <= '0;
         err_q        <= 1'b0;
         byte_q       <= 8'd0;
         byte_vld_q   <= 1'b0;
         brk_q        <= 1'b0;
         ext_q        <= 1'b0;
         dec_push_q   <= 1'b0;
         dec_letter_q <= 5'd0;
      end else begin
         kclk_filt_q  <= kclk_filt_d;
         flt_cnt_q    <= flt_cnt_d;
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         tmo_q        <= tmo_d;
         err_q        <= err_d;
         byte_q       <= byte_d;
         byte_vld_q   <= byte_vld_d;
         brk_q        <= brk_d;
         ext_q        <= ext_d;
         dec_push_q   <= dec_push_d;
         dec_letter_q <= dec_letter_d;
      end
   end

   // Scan-code set 2 make codes for A..Z
   always_comb begin
      case (byte_q)
         8'h1C: scan_letter = 5'd1;   8'h32: scan_letter = 5'd2;   8'h21: scan_letter = 5'd3;
         8'h23: scan_letter = 5'd4;   8'h24: scan_letter = 5'd5;   8'h2B: scan_letter = 5'd6;
         8'h34: scan_letter = 5'd7;   8'h33: scan_letter = 5'd8;   8'h43: scan_letter = 5'd9;
         8'h3B: scan_letter = 5'd10;  8'h42: scan_letter = 5'd11;  8'h4B: scan_letter = 5'd12;
         8'h3A: scan_letter = 5'd13;  8'h31: scan_letter = 5'd14;  8'h44: scan_letter = 5'd15;
         8'h4D: scan_letter = 5'd16;  8'h15: scan_letter = 5'd17;  8'h2D: scan_letter = 5'd18;
         8'h1B: scan_letter = 5'd19;  8'h2C: scan_letter = 5'd20;  8'h3C: scan_letter = 5'd21;
         8'h2A: scan_letter = 5'd22;  8'h1D: scan_letter = 5'd23;  8'h22: scan_letter = 5'd24;
         8'h35: scan_letter = 5'd25;  8'h1A: scan_letter = 5'd26;
         default: scan_letter = 5'd0;
      endcase
   end

   // Decoder: break/extended prefixes swallow the following byte; letters become push requests
   always_comb begin
      brk_d        = brk_q;
      ext_d        = ext_q;
      dec_push_d   = 1'b0;
      dec_letter_d = dec_letter_q;
      if (byte_vld_q) begin
         if (byte_q == 8'hF0) begin
            brk_d = 1'b1;
         end else if (byte_q == 8'hE0) begin
            ext_d = 1'b1;
         end else if (brk_q || ext_q) begin
            brk_d = 1'b0;
            ext_d = 1'b0;
         end else if (scan_letter != 5'd0) begin
            dec_push_d   = 1'b1;
            dec_letter_d = scan_letter;
         end
      end
   end

   assign full    = (count_q == CNT_W'(FIFO_DEPTH));
   assign pop     = (count_q != '0) && letter_ready;
   assign push_ok = dec_push_q && (!full || pop);

   // FIFO bookkeeping: a push into a full FIFO only succeeds when a pop frees the slot that cycle
   always_comb begin
      wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      last_d   = last_q;
      if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push_ok && pop) count_d = count_q - CNT_W'(1);
      if (dec_push_q) begin
         last_d = LETTER_W'(dec_letter_q);
         if (!push_ok) ovf_d = 1'b1;
      end
   end

   // FIFO pointer, count and status registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         last_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         last_q   <= last_d;
      end
   end

   // FIFO storage; contents need no reset since validity is tracked by count_q
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= LETTER_W'(dec_letter_q);
   end

   assign letter_valid = (count_q != '0);
   assign letter_o     = letter_valid ? mem_q[rd_ptr_q] : '0;
   assign last_letter  = last_q;
   assign fifo_count   = count_q;
   assign overflow     = ovf_q;
   assign frame_err    = err_q;

endmodule
